// File: rtl/seq_mult_shift_add_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding, default operand width and the iteration
// counter width helper.
package seq_mult_shift_add_pkg;

  // Default operand width; the product is twice this wide.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states. The 2'b11 code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed for a counter that has to hold the value WIDTH itself.
  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_ripple_add_n.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// It is purely combinational. At WIDTH=4 it behaves like the classic 4-bit adder.
module ripple_add_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  logic [WIDTH:0] carry;

  assign carry[0] = carryIn;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : gen_fa
      // One full-adder cell. The carry ripples from bit i into bit i+1.
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign carryOut = carry[WIDTH];

endmodule

// File: rtl/seq_mult_shift_add.sv
// Multi-cycle unsigned shift-and-add multiplier. Each RUN cycle adds the
// multiplicand to the upper half when Q[0] is set. It then shifts
// {carry, acc, Q} right by one. After WIDTH iterations the product is
// {acc, Q}. Handshake: start accepted in IDLE, busy in RUN, one-cycle done.
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = countWidth(WIDTH);

  state_t state;
  state_t nextState;

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] addB;
  logic [WIDTH-1:0] addSum;
  logic             addCarry;

  // The partial product is either the multiplicand or zero, chosen by the current multiplier LSB.
  always_comb begin
    addB = '0;
    if (q[0]) addB = m;
  end

  ripple_add_n #(.WIDTH(WIDTH)) u_adder (
    .a        (acc),
    .b        (addB),
    .carryIn  (1'b0),
    .sum      (addSum),
    .carryOut (addCarry)
  );

  // State register: the asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic: leave RUN on the last iteration, and send any unknown code back to IDLE.
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = start ? RUN : IDLE;
      RUN:     nextState = (count == CW'(1)) ? DONE : RUN;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the state, so the unused code drives both low.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, then do one add/shift per RUN cycle, and capture the product on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            count <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc   <= {addCarry, addSum[WIDTH-1:1]};
          q     <= {addSum[0], q[WIDTH-1:1]};
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            product <= {addCarry, addSum, q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add at WIDTH=4. A table of operand
// pairs with hand-computed products drives the single-operation checks.
// Hand-written sequences cover back-to-back starts and an asynchronous reset mid-operation.
module tb_seq_mult_shift_add;

  localparam int W = 4;

  typedef struct {
    string        name;
    logic [W-1:0] mc;
    logic [W-1:0] mp;
    logic [2*W-1:0] prod;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int passCount;
  int checkCount;

  vec_t vecs[6];

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one and tally the result.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Run one multiplication from IDLE. Check busy for WIDTH cycles, then the done pulse, the product, and that the product is held.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    multiplicand = v.mc;
    multiplier   = v.mp;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checkOutput($sformatf("%s busy/done run%0d", v.name, i), {14'd0, busy, done}, 16'b10);
      multiplicand = ~v.mc;
      multiplier   = ~v.mp;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput($sformatf("%s done pulse", v.name), {14'd0, busy, done}, 16'b01);
    checkOutput($sformatf("%s product", v.name), {8'd0, product}, {8'd0, v.prod});
    @(negedge clk);
    checkOutput($sformatf("%s done cleared", v.name), {14'd0, busy, done}, 16'b00);
    checkOutput($sformatf("%s product held", v.name), {8'd0, product}, {8'd0, v.prod});
  endtask

  initial begin
    passCount    = 0;
    checkCount   = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{"13x11", 4'd13, 4'd11, 8'h8F};
    vecs[1] = '{"15x15", 4'd15, 4'd15, 8'hE1};
    vecs[2] = '{"0x9",   4'd0,  4'd9,  8'h00};
    vecs[3] = '{"1x7",   4'd1,  4'd7,  8'h07};
    vecs[4] = '{"7x1",   4'd7,  4'd1,  8'h07};
    vecs[5] = '{"9x14",  4'd9,  4'd14, 8'h7E};

    // Reset held for three cycles, then ten idle cycles with start low.
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", {5'd0, busy, done, product, 1'b0}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle%0d outputs", i), {6'd0, busy, done, product}, 16'd0);
    end

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Start held high: (3,5) then (6,6). Done is expected at negedges 5 and 11 after acceptance.
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start        = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        multiplicand = 4'd6;
        multiplier   = 4'd6;
      end
      if (n == 7) begin
        multiplicand = 4'd15;
        multiplier   = 4'd15;
      end
      checkOutput($sformatf("b2b done n%0d", n), {15'd0, done}, {15'd0, (n == 5 || n == 11)});
      if (n == 5)  checkOutput("b2b product 3x5", {8'd0, product}, 16'h000F);
      if (n == 11) begin
        checkOutput("b2b product 6x6", {8'd0, product}, 16'h0024);
        start = 1'b0;
      end
    end

    // Reset mid-operation: start 12x12 and abort after two RUN cycles.
    @(negedge clk);
    multiplicand = 4'd12;
    multiplier   = 4'd12;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy/done", {14'd0, busy, done}, 16'b00);
    checkOutput("abort product", {8'd0, product}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post-abort quiet%0d", i), {6'd0, busy, done, product}, 16'd0);
    end
    applyStimulus('{"2x3 after abort", 4'd2, 4'd3, 8'h06});

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
